// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART frame loader: FSM encodings, error codes, sync marker.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PIXELS   = 3'd1,
    ST_CHECKSUM = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_FRAME    = 3'd1;
  localparam logic [2:0] ERR_RANGE    = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // True when a received byte fits in the stored pixel width.
  function automatic logic pixel_in_range(input logic [7:0] b, input int unsigned pix_w);
    return (b >> pix_w) == 8'd0;
  endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte watchdog: counts while run is high, restarts on kick, flags the last count.
module rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: cleared outside a frame or on any byte, saturates at the last value.
  always_comb begin
    count_d = count_q + 1'b1;
    if (!run || kick) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == LAST);

endmodule

// File: rtl/uart_frame_loader.sv
// Loads a sync-prefixed, XOR-checksummed pixel stream from uart_rx into the frame buffer.
module uart_frame_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned IMG_W          = 160,
  parameter int unsigned IMG_H          = 120,
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned PIX_W          = 3,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_error,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  output logic              busy,
  output logic              load_done,
  output logic              load_error,
  output logic [2:0]        err_code,
  output logic [2:0]        state
);

  localparam int unsigned       NPIX     = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [7:0]          chk_q, chk_d;
  logic                fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0]    fb_data_q, fb_data_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                timer_run, timer_expired;

  assign timer_run = (state_q == ST_PIXELS) || (state_q == ST_CHECKSUM);

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (timer_run),
    .kick   (rx_valid),
    .expired(timer_expired)
  );

  // Next-state and registered-output logic; frame error beats a byte, a byte beats timeout.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    chk_d        = chk_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
    err_code_d   = err_code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d      = ST_PIXELS;
          count_d      = '0;
          chk_d        = 8'd0;
          load_error_d = 1'b0;
          err_code_d   = ERR_NONE;
        end
      end
      ST_PIXELS: begin
        if (rx_frame_error) begin
          state_d      = ST_ERROR;
          load_error_d = 1'b1;
          err_code_d   = ERR_FRAME;
        end else if (rx_valid) begin
          if (pixel_in_range(rx_data, PIX_W)) begin
            fb_we_d   = 1'b1;
            fb_addr_d = count_q;
            fb_data_d = rx_data[PIX_W-1:0];
            chk_d     = chk_q ^ rx_data;
            count_d   = count_q + 1'b1;
            if (count_q == LAST_PIX) begin
              state_d = ST_CHECKSUM;
            end
          end else begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
            err_code_d   = ERR_RANGE;
          end
        end else if (timer_expired) begin
          state_d      = ST_ERROR;
          load_error_d = 1'b1;
          err_code_d   = ERR_TIMEOUT;
        end
      end
      ST_CHECKSUM: begin
        if (rx_frame_error) begin
          state_d      = ST_ERROR;
          load_error_d = 1'b1;
          err_code_d   = ERR_FRAME;
        end else if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
          end else begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
            err_code_d   = ERR_CHECKSUM;
          end
        end else if (timer_expired) begin
          state_d      = ST_ERROR;
          load_error_d = 1'b1;
          err_code_d   = ERR_TIMEOUT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_PIXELS) || (state_d == ST_CHECKSUM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      chk_q        <= 8'd0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      chk_q        <= chk_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign err_code   = err_code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader on a 4x2 image with a 200-cycle byte timeout.
module tb_uart_frame_loader;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned PIX_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_frame_error = 1'b0;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              busy;
  logic              load_done;
  logic              load_error;
  logic [2:0]        err_code;
  logic [2:0]        state;

  int vectors = 0;
  int miscompares = 0;

  uart_frame_loader #(
    .IMG_W(4), .IMG_H(2), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_error(rx_frame_error), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .busy(busy), .load_done(load_done),
    .load_error(load_error), .err_code(err_code), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle uart_rx style pulse; returns at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_write(input string tag, input int a, input int d);
    check({tag, "_we"},   32'(fb_we),   32'd1);
    check({tag, "_addr"}, 32'(fb_addr), 32'(a));
    check({tag, "_data"}, 32'(fb_data), 32'(d));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(fb_we),      32'd0);
    check({tag, "_addr"},  32'(fb_addr),    32'd0);
    check({tag, "_data"},  32'(fb_data),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(load_done),  32'd0);
    check({tag, "_lerr"},  32'(load_error), 32'd0);
    check({tag, "_code"},  32'(err_code),   32'd0);
    check({tag, "_state"}, 32'(state),      32'd0);
  endtask

  initial begin
    // Reset
    idle(3);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Frame error and stray bytes in IDLE are ignored
    @(negedge clk);
    rx_frame_error = 1'b1;
    @(negedge clk);
    rx_frame_error = 1'b0;
    check("idle_ferr_state", 32'(state), 32'd0);
    check("idle_ferr_lerr", 32'(load_error), 32'd0);

    // 1: good frame 00..07, checksum 00
    send_byte(8'hA5);
    check("t1_sync_state", 32'(state), 32'd1);
    check("t1_sync_busy", 32'(busy), 32'd1);
    check("t1_sync_we", 32'(fb_we), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i));
      check_write("t1_px", i, i);
    end
    check("t1_chk_state", 32'(state), 32'd2);
    send_byte(8'h00);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_done_state", 32'(state), 32'd3);
    check("t1_done_lerr", 32'(load_error), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);
    idle(1);
    check("t1_done_pulse", 32'(load_done), 32'd0);
    check("t1_idle_state", 32'(state), 32'd0);

    // 2: 07 x8 gives checksum 00, 01 sent -> checksum error
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h07);
      check_write("t2_px", i, 7);
    end
    send_byte(8'h01);
    check("t2_err_state", 32'(state), 32'd4);
    check("t2_lerr", 32'(load_error), 32'd1);
    check("t2_code", 32'(err_code), 32'd3);
    check("t2_done", 32'(load_done), 32'd0);
    idle(6);
    check("t2_sticky_state", 32'(state), 32'd0);
    check("t2_sticky_lerr", 32'(load_error), 32'd1);
    check("t2_sticky_code", 32'(err_code), 32'd3);

    // 3: range error on 09
    send_byte(8'hA5);
    check("t3_clr_lerr", 32'(load_error), 32'd0);
    check("t3_clr_code", 32'(err_code), 32'd0);
    send_byte(8'h01);
    check_write("t3_px0", 0, 1);
    send_byte(8'h02);
    check_write("t3_px1", 1, 2);
    send_byte(8'h09);
    check("t3_nowrite", 32'(fb_we), 32'd0);
    check("t3_addr_hold", 32'(fb_addr), 32'd1);
    check("t3_state", 32'(state), 32'd4);
    check("t3_code", 32'(err_code), 32'd2);
    idle(1);
    check("t3_back_idle", 32'(state), 32'd0);

    // 4: frame error coincident with a valid byte
    send_byte(8'hA5);
    send_byte(8'h01);
    check_write("t4_px0", 0, 1);
    @(negedge clk);
    rx_data = 8'h02;
    rx_valid = 1'b1;
    rx_frame_error = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_frame_error = 1'b0;
    check("t4_nowrite", 32'(fb_we), 32'd0);
    check("t4_state", 32'(state), 32'd4);
    check("t4_code", 32'(err_code), 32'd1);
    check("t4_lerr", 32'(load_error), 32'd1);

    // 5: timeout after 200 quiet cycles, then a new sync clears the flag
    send_byte(8'hA5);
    send_byte(8'h01);
    check_write("t5_px0", 0, 1);
    idle(150);
    check("t5_early_lerr", 32'(load_error), 32'd0);
    check("t5_early_state", 32'(state), 32'd1);
    idle(60);
    check("t5_lerr", 32'(load_error), 32'd1);
    check("t5_code", 32'(err_code), 32'd4);
    check("t5_state", 32'(state), 32'd0);
    send_byte(8'hA5);
    check("t5_resync_lerr", 32'(load_error), 32'd0);
    check("t5_resync_busy", 32'(busy), 32'd1);
    check("t5_resync_code", 32'(err_code), 32'd0);

    // 6: reset mid-frame, then only the sync byte is accepted in IDLE
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(i + 4));
      check_write("t6_px", i, i + 4);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t6_rst");
    send_byte(8'h11);
    check("t6_ign_state", 32'(state), 32'd0);
    check("t6_ign_busy", 32'(busy), 32'd0);
    check("t6_ign_we", 32'(fb_we), 32'd0);
    send_byte(8'hA5);
    check("t6_sync_state", 32'(state), 32'd1);
    check("t6_sync_busy", 32'(busy), 32'd1);
    check("t6_sync_we", 32'(fb_we), 32'd0);
    check("t6_sync_done", 32'(load_done), 32'd0);
    check("t6_sync_lerr", 32'(load_error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
